sel_mux_stage: RTL and testbench

- Parametrised N:1 select stage with one registered output and a valid/ready handshake on every input and on the output.
- Successor to the fixed 5-bit 2:1 combinational fetch select.
- Adds configurable width and channel count, a fixed-select or round-robin mode, flush, and backpressure.
- Sits between the fetch/decode sources and the consumer that needs a registered, arbitrated operand or address.

---
 rtl/sel_mux_stage.sv | 138 +++++++++++++
 tb/tb_sel_mux_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_mux_stage.sv
// N:1 select stage with a registered, handshaked output; fixed-select or round-robin grant.
// Define SEL_MUX_SKID_EN to add a one-entry skid register that decouples in_ready from out_ready.
module sel_mux_stage #(
   parameter  int WIDTH   = 5,
   parameter  int NUM_IN  = 2,
   parameter  int RR_MODE = 0,
   localparam int SEL_W   = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gnt;
   logic             gnt_vld;
   logic [WIDTH-1:0] gnt_data;
   logic             load_en;
   logic             accept_ok;
   logic             xfer;

   assign load_en = !out_valid || out_ready;

`ifdef SEL_MUX_SKID_EN
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic [SEL_W-1:0] skid_sel;

   assign accept_ok = !skid_valid && !flush;
`else
   assign accept_ok = load_en && !flush;
`endif

   // Grant: fixed channel from sel, or first valid channel at/after ptr.
   always_comb begin
      int               idx;
      logic [SEL_W-1:0] idx_s;
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      idx_s   = '0;
      if (RR_MODE == 0) begin
         gnt     = sel;
         gnt_vld = (int'(sel) < NUM_IN);
      end else begin
         for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            idx_s = idx[SEL_W-1:0];
            if (!gnt_vld && in_valid[idx_s]) begin
               gnt_vld = 1'b1;
               gnt     = idx_s;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (int'(gnt) == i) begin
            in_ready[i] = rst_n && gnt_vld && accept_ok;
            gnt_data    = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // in_ready is one-hot, so any matching valid bit is the granted transfer
   assign xfer = |(in_valid & in_ready);

   // Output register stage; a new beat may load as the old one leaves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
`ifdef SEL_MUX_SKID_EN
         skid_valid <= 1'b0;
`endif
      end else begin
`ifdef SEL_MUX_SKID_EN
         if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
         end else if (load_en) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_data   <= skid_data;
               out_sel    <= skid_sel;
               skid_valid <= 1'b0;
            end else if (xfer) begin
               out_valid <= 1'b1;
               out_data  <= gnt_data;
               out_sel   <= gnt;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (xfer) begin
            skid_valid <= 1'b1;
         end
`else
         if (flush) begin
            out_valid <= 1'b0;
         end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
`endif
         if (xfer && (RR_MODE != 0)) begin
            ptr <= (int'(gnt) == NUM_IN - 1) ? '0 : gnt + SEL_W'(1);
         end
      end
   end

`ifdef SEL_MUX_SKID_EN
   // Skid payload stage: captured only when a beat is accepted during a stall.
   always_ff @(posedge clk) begin
      if (!flush && !load_en && xfer) begin
         skid_data <= gnt_data;
         skid_sel  <= gnt;
      end
   end
`endif

endmodule

// File: tb/tb_sel_mux_stage.sv
// Scoreboard bench for sel_mux_stage: fixed 2:1, round-robin 4:1 and fixed 3:1 instances.
module tb_sel_mux_stage;

   typedef struct packed {
      logic [4:0] d;
      logic [1:0] s;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   beat_t qa[$];
   beat_t qb[$];
   beat_t qc[$];
   beat_t ea, eb, ec;

   logic       a_flush, a_ovld, a_ordy;
   logic [0:0] a_sel, a_osel;
   logic [9:0] a_data;
   logic [1:0] a_vld, a_rdy;
   logic [4:0] a_odata;

   logic        b_flush, b_ovld, b_ordy;
   logic [1:0]  b_sel, b_osel;
   logic [19:0] b_data;
   logic [3:0]  b_vld, b_rdy;
   logic [4:0]  b_odata;

   logic        c_flush, c_ovld, c_ordy;
   logic [1:0]  c_sel, c_osel;
   logic [14:0] c_data;
   logic [2:0]  c_vld, c_rdy;
   logic [4:0]  c_odata;

   logic [4:0] rrd [4] = '{5'h04, 5'h09, 5'h12, 5'h1B};

   always #5 clk = ~clk;

   sel_mux_stage #(.WIDTH(5), .NUM_IN(2), .RR_MODE(0)) u_fix2 (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .sel(a_sel),
      .in_data(a_data), .in_valid(a_vld), .in_ready(a_rdy),
      .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovld), .out_ready(a_ordy));

   sel_mux_stage #(.WIDTH(5), .NUM_IN(4), .RR_MODE(1)) u_rr4 (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .sel(b_sel),
      .in_data(b_data), .in_valid(b_vld), .in_ready(b_rdy),
      .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovld), .out_ready(b_ordy));

   sel_mux_stage #(.WIDTH(5), .NUM_IN(3), .RR_MODE(0)) u_fix3 (
      .clk(clk), .rst_n(rst_n), .flush(c_flush), .sel(c_sel),
      .in_data(c_data), .in_valid(c_vld), .in_ready(c_rdy),
      .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovld), .out_ready(c_ordy));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitors: a beat is consumed on an output handshake that flush does not override
   always @(negedge clk) begin
      if (rst_n && a_ovld && a_ordy && !a_flush) begin
         if (qa.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected: got beat 0x%0h/%0d expected none", a_odata, a_osel);
         end else begin
            ea = qa.pop_front();
            chk("a_data", 32'(a_odata), 32'(ea.d));
            chk("a_sel", 32'(a_osel), 32'(ea.s));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_ovld && b_ordy && !b_flush) begin
         if (qb.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected: got beat 0x%0h/%0d expected none", b_odata, b_osel);
         end else begin
            eb = qb.pop_front();
            chk("b_data", 32'(b_odata), 32'(eb.d));
            chk("b_sel", 32'(b_osel), 32'(eb.s));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && c_ovld && c_ordy && !c_flush) begin
         if (qc.size() == 0) begin
            checks++; failures++;
            $display("FAIL c_unexpected: got beat 0x%0h/%0d expected none", c_odata, c_osel);
         end else begin
            ec = qc.pop_front();
            chk("c_data", 32'(c_odata), 32'(ec.d));
            chk("c_sel", 32'(c_osel), 32'(ec.s));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_flush = 0; a_sel = 1; a_data = '0; a_vld = 2'b11; a_ordy = 1;
      b_flush = 0; b_sel = 0; b_data = '0; b_vld = 4'hF;  b_ordy = 1;
      c_flush = 0; c_sel = 0; c_data = '0; c_vld = 3'h7;  c_ordy = 1;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_a_ovld", 32'(a_ovld), 0);
      chk("rst_a_odata", 32'(a_odata), 0);
      chk("rst_a_osel", 32'(a_osel), 0);
      chk("rst_a_rdy", 32'(a_rdy), 0);
      chk("rst_b_rdy", 32'(b_rdy), 0);
      chk("rst_c_rdy", 32'(c_rdy), 0);
      a_vld = 0; b_vld = 0; c_vld = 0;
      #1 rst_n = 1'b1;
      step();

      // fixed 2:1 basic select
      a_sel = 1; a_data = {5'h0A, 5'h15}; a_vld = 2'b11; a_ordy = 1;
      @(negedge clk);
      chk("t1_rdy", 32'(a_rdy), 32'b10);
      qa.push_back('{d: 5'h0A, s: 2'd1});
      step();
      chk("t1_ovld", 32'(a_ovld), 1);
      chk("t1_odata", 32'(a_odata), 32'h0A);
      chk("t1_osel", 32'(a_osel), 1);
      a_vld = 0;
      step();
      chk("t1_drain_ovld", 32'(a_ovld), 0);
      chk("t1_drain_hold", 32'(a_odata), 32'h0A);

      // stall with toggling sel/data
      a_sel = 0; a_data = {5'h1C, 5'h03}; a_vld = 2'b01; a_ordy = 0;
      qa.push_back('{d: 5'h03, s: 2'd0});
      step();
      chk("st_ovld", 32'(a_ovld), 1);
      chk("st_odata", 32'(a_odata), 32'h03);
      for (int i = 0; i < 3; i++) begin
         a_sel = ~a_sel;
         a_data = ~a_data;
`ifdef SEL_MUX_SKID_EN
         a_vld = 2'b00;
         @(negedge clk);
         chk("st_rdy", 32'(a_rdy), 32'(2'b01 << a_sel));
`else
         a_vld = 2'b11;
         @(negedge clk);
         chk("st_rdy", 32'(a_rdy), 0);
`endif
         step();
         chk("st_hold_data", 32'(a_odata), 32'h03);
         chk("st_hold_sel", 32'(a_osel), 0);
      end
      a_ordy = 1; a_sel = 1; a_data = {5'h11, 5'h02}; a_vld = 2'b10;
      @(negedge clk);
      chk("st_release_rdy", 32'(a_rdy), 32'b10);
      qa.push_back('{d: 5'h11, s: 2'd1});
      step();
      chk("st_new_data", 32'(a_odata), 32'h11);
      chk("st_new_sel", 32'(a_osel), 1);
      a_vld = 0;
      step();

      // round-robin 4:1, all valid
      b_data = {rrd[3], rrd[2], rrd[1], rrd[0]}; b_vld = 4'hF; b_ordy = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_rdy", 32'(b_rdy), 32'(1) << (i % 4));
         qb.push_back('{d: rrd[i % 4], s: 2'(i % 4)});
         step();
         chk("rr_osel", 32'(b_osel), 32'(i % 4));
      end
      b_vld = 0;
      step();
      chk("rr_drain_ovld", 32'(b_ovld), 0);

      // flush against a simultaneous input transfer and out_ready
      b_vld = 4'hF; b_ordy = 0;
      @(negedge clk);
      chk("fl_pre_rdy", 32'(b_rdy), 32'b0100);
      qb.push_back('{d: 5'h12, s: 2'd2});
      step();
      chk("fl_pre_osel", 32'(b_osel), 2);
      b_flush = 1; b_ordy = 1;
      void'(qb.pop_back());
      @(negedge clk);
      chk("fl_rdy", 32'(b_rdy), 0);
      step();
      chk("fl_ovld", 32'(b_ovld), 0);
      b_flush = 0;
      @(negedge clk);
      chk("fl_ptr_rdy", 32'(b_rdy), 32'b1000);
      qb.push_back('{d: 5'h1B, s: 2'd3});
      step();
      chk("fl_post_osel", 32'(b_osel), 3);
      chk("fl_post_odata", 32'(b_odata), 32'h1B);
      @(negedge clk);
      chk("rr_wrap_rdy", 32'(b_rdy), 32'b0001);
      qb.push_back('{d: 5'h04, s: 2'd0});
      step();
      b_vld = 0;
      step();

      // fixed 3:1, out-of-range sel then a legal one
      c_data = {5'h0E, 5'h0D, 5'h0C}; c_vld = 3'b111; c_sel = 3; c_ordy = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("c_bad_rdy", 32'(c_rdy), 0);
         step();
         chk("c_bad_ovld", 32'(c_ovld), 0);
      end
      c_sel = 2;
      @(negedge clk);
      chk("c_rdy", 32'(c_rdy), 32'b100);
      qc.push_back('{d: 5'h0E, s: 2'd2});
      step();
      chk("c_osel", 32'(c_osel), 2);
      chk("c_odata", 32'(c_odata), 32'h0E);
      c_vld = 0;
      step();

      // asynchronous reset mid-operation
      a_sel = 0; a_data = {5'h00, 5'h1F}; a_vld = 2'b01; a_ordy = 0;
      qa.push_back('{d: 5'h1F, s: 2'd0});
      step();
      chk("mr_ovld", 32'(a_ovld), 1);
      chk("mr_odata", 32'(a_odata), 32'h1F);
      a_vld = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("mr_rst_ovld", 32'(a_ovld), 0);
      chk("mr_rst_odata", 32'(a_odata), 0);
      qa.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      a_ordy = 1;
      step();
      b_vld = 4'hF;
      @(negedge clk);
      chk("mr_ptr_rdy", 32'(b_rdy), 32'b0001);
      qb.push_back('{d: 5'h04, s: 2'd0});
      step();
      chk("mr_ptr_osel", 32'(b_osel), 0);
      b_vld = 0;
      step();

`ifdef SEL_MUX_SKID_EN
      // two beats accepted across a stall come out in order
      a_ordy = 0; a_sel = 0; a_data = {5'h06, 5'h05}; a_vld = 2'b01;
      @(negedge clk);
      chk("sk_rdy0", 32'(a_rdy), 32'b01);
      qa.push_back('{d: 5'h05, s: 2'd0});
      step();
      a_sel = 1; a_vld = 2'b10;
      @(negedge clk);
      chk("sk_rdy1", 32'(a_rdy), 32'b10);
      qa.push_back('{d: 5'h06, s: 2'd1});
      step();
      chk("sk_hold", 32'(a_odata), 32'h05);
      a_sel = 0; a_vld = 2'b01;
      @(negedge clk);
      chk("sk_full_rdy", 32'(a_rdy), 0);
      step();
      a_vld = 0; a_ordy = 1;
      step();
      chk("sk_second_data", 32'(a_odata), 32'h06);
      chk("sk_second_sel", 32'(a_osel), 1);
      step();
      chk("sk_drain_ovld", 32'(a_ovld), 0);
`endif

      step();
      chk("qa_empty", 32'(qa.size()), 0);
      chk("qb_empty", 32'(qb.size()), 0);
      chk("qc_empty", 32'(qc.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
